// File: rtl/cpu_status_reg.sv
// Processor status (P) register fed by the ALU's registered flags, with flag ops, BIT, PLP/RTI and interrupt entry.
// Define CMOS_FLAGS_EN for 65C02 behaviour (irq_entry clears D, BIT immediate skips N/V load).
module cpu_status_reg #(
  parameter logic RESET_I = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RDY,
  input  logic       flag_req,
  input  logic [3:0] flag_mask,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic [2:0] flag_op,
  input  logic       bit_load,
  input  logic       plp_load,
  input  logic [7:0] DI,
  input  logic       irq_entry,
  input  logic       brk,
  output logic       C,
  output logic       Z,
  output logic       I,
  output logic       D,
  output logic       V,
  output logic       N,
  output logic [7:0] P_push,
  output logic       pend
);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_SEC  = 3'd1,
    OP_CLC  = 3'd2,
    OP_SEI  = 3'd3,
    OP_CLI  = 3'd4,
    OP_SED  = 3'd5,
    OP_CLD  = 3'd6,
    OP_CLV  = 3'd7
  } flag_op_e;

  logic       r_c, r_z, r_i, r_d, r_v, r_n;
  logic       r_pend;
  logic [3:0] r_pmask;  // {N,V,Z,C}

  logic       w_c_nxt, w_z_nxt, w_i_nxt, w_d_nxt, w_v_nxt, w_n_nxt;
  logic       w_bit_nv;
  logic       w_irq_d;
  flag_op_e   w_op;
  logic       w_unused;

  assign w_op     = flag_op_e'(flag_op);
  assign w_unused = ^DI[5:4];

`ifdef CMOS_FLAGS_EN
  assign w_bit_nv = bit_load && !flag_mask[1];
  assign w_irq_d  = irq_entry;
`else
  assign w_bit_nv = bit_load;
  assign w_irq_d  = 1'b0;
`endif

  // Per-flag priority: plp_load, pending ALU apply, bit_load, flag_op, irq_entry.
  always_comb begin
    // NOTE: every output gets a hold default first so no path leaves it unassigned (no latch).
    w_c_nxt = r_c;
    w_z_nxt = r_z;
    w_i_nxt = r_i;
    w_d_nxt = r_d;
    w_v_nxt = r_v;
    w_n_nxt = r_n;

    if (plp_load)                   w_c_nxt = DI[0];
    else if (r_pend && r_pmask[0])  w_c_nxt = alu_co;
    else if (w_op == OP_SEC)        w_c_nxt = 1'b1;
    else if (w_op == OP_CLC)        w_c_nxt = 1'b0;

    if (plp_load)                   w_z_nxt = DI[1];
    else if (r_pend && r_pmask[1])  w_z_nxt = alu_z;

    if (plp_load)                   w_i_nxt = DI[2];
    else if (w_op == OP_SEI)        w_i_nxt = 1'b1;
    else if (w_op == OP_CLI)        w_i_nxt = 1'b0;
    else if (irq_entry)             w_i_nxt = 1'b1;

    if (plp_load)                   w_d_nxt = DI[3];
    else if (w_op == OP_SED)        w_d_nxt = 1'b1;
    else if (w_op == OP_CLD)        w_d_nxt = 1'b0;
    else if (w_irq_d)               w_d_nxt = 1'b0;

    if (plp_load)                   w_v_nxt = DI[6];
    else if (r_pend && r_pmask[2])  w_v_nxt = alu_v;
    else if (w_bit_nv)              w_v_nxt = DI[6];
    else if (w_op == OP_CLV)        w_v_nxt = 1'b0;

    if (plp_load)                   w_n_nxt = DI[7];
    else if (r_pend && r_pmask[3])  w_n_nxt = alu_n;
    else if (w_bit_nv)              w_n_nxt = DI[7];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_i     <= RESET_I;
      r_d     <= 1'b0;
      r_v     <= 1'b0;
      r_n     <= 1'b0;
      r_pend  <= 1'b0;
      r_pmask <= 4'b0000;
    end else if (RDY) begin
      r_c    <= w_c_nxt;
      r_z    <= w_z_nxt;
      r_i    <= w_i_nxt;
      r_d    <= w_d_nxt;
      r_v    <= w_v_nxt;
      r_n    <= w_n_nxt;
      // A new request always re-arms; otherwise the apply (or a PLP) retires the pending update.
      r_pend <= flag_req;
      if (flag_req) r_pmask <= flag_mask;
    end
  end

  assign C      = r_c;
  assign Z      = r_z;
  assign I      = r_i;
  assign D      = r_d;
  assign V      = r_v;
  assign N      = r_n;
  assign pend   = r_pend;
  assign P_push = {r_n, r_v, 1'b1, brk, r_d, r_i, r_z, r_c};

endmodule

// File: tb/tb_cpu_status_reg.sv
// Self-checking bench for cpu_status_reg: directed vector table, corner sequences, randomized model comparison.
module tb_cpu_status_reg;

  localparam logic RESET_I = 1'b1;

  logic       clk = 1'b0;
  logic       reset, RDY, flag_req, alu_co, alu_v, alu_z, alu_n;
  logic       bit_load, plp_load, irq_entry, brk;
  logic [3:0] flag_mask;
  logic [2:0] flag_op;
  logic [7:0] DI;
  logic       C, Z, I, D, V, N, pend;
  logic [7:0] P_push;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_status_reg #(.RESET_I(RESET_I)) dut (
    .clk(clk), .reset(reset), .RDY(RDY), .flag_req(flag_req), .flag_mask(flag_mask),
    .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .flag_op(flag_op),
    .bit_load(bit_load), .plp_load(plp_load), .DI(DI), .irq_entry(irq_entry), .brk(brk),
    .C(C), .Z(Z), .I(I), .D(D), .V(V), .N(N), .P_push(P_push), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       req;
    logic [3:0] mask;
    logic [3:0] alu;   // {n,v,z,c}
    logic [2:0] op;
    logic       bitl;
    logic       plp;
    logic [7:0] di;
    logic       irq;
    logic       brk;
    logic [7:0] exp_push;
    logic       exp_pend;
  } vec_t;

  vec_t vecs[12];

  // Reference state: P byte image (bits 5/4 unused) plus the pending request.
  logic [7:0] m_p;
  logic       m_pend;
  logic [3:0] m_pmask;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    RDY = v.rdy; flag_req = v.req; flag_mask = v.mask;
    {alu_n, alu_v, alu_z, alu_co} = v.alu;
    flag_op = v.op; bit_load = v.bitl; plp_load = v.plp; DI = v.di;
    irq_entry = v.irq; brk = v.brk;
  endtask

  task automatic idle();
    vec_t v = '{rdy:1'b1, req:1'b0, mask:4'h0, alu:4'h0, op:3'd0, bitl:1'b0, plp:1'b0,
                di:8'h00, irq:1'b0, brk:1'b0, exp_push:8'h00, exp_pend:1'b0};
    drive(v);
  endtask

  task automatic tick_check(input string name, input logic [7:0] exp_push, input logic exp_pend);
    @(posedge clk); #1;
    check({name, ".push"}, P_push, exp_push);
    check({name, ".pend"}, {7'b0, pend}, {7'b0, exp_pend});
  endtask

  // Applies the sources lowest-priority first so that higher ones overwrite.
  task automatic model_edge();
    logic [7:0] np;
    if (reset) begin
      m_p = 8'h00; m_p[2] = RESET_I; m_pend = 1'b0; m_pmask = 4'h0;
    end else if (RDY) begin
      np = m_p;
      if (irq_entry) begin
        np[2] = 1'b1;
`ifdef CMOS_FLAGS_EN
        np[3] = 1'b0;
`endif
      end
      case (flag_op)
        3'd1: np[0] = 1'b1;
        3'd2: np[0] = 1'b0;
        3'd3: np[2] = 1'b1;
        3'd4: np[2] = 1'b0;
        3'd5: np[3] = 1'b1;
        3'd6: np[3] = 1'b0;
        3'd7: np[6] = 1'b0;
        default: ;
      endcase
`ifdef CMOS_FLAGS_EN
      if (bit_load && !flag_mask[1]) begin
`else
      if (bit_load) begin
`endif
        np[7] = DI[7]; np[6] = DI[6];
      end
      if (m_pend) begin
        if (m_pmask[0]) np[0] = alu_co;
        if (m_pmask[1]) np[1] = alu_z;
        if (m_pmask[2]) np[6] = alu_v;
        if (m_pmask[3]) np[7] = alu_n;
      end
      if (plp_load) np = DI;
      m_p    = np;
      m_pend = flag_req;
      if (flag_req) m_pmask = flag_mask;
    end
  endtask

  initial begin
    // Sequence starting from reset (I=1): P_push = {N,V,1,B,D,I,Z,C}.
    vecs[0]  = '{1,1,4'hF,4'b0000,3'd0,0,0,8'h00,0,0, 8'h24,1};  // capture, flags unchanged
    vecs[1]  = '{1,0,4'h0,4'b1101,3'd0,0,0,8'h00,0,0, 8'hE5,0};  // apply N V C
    vecs[2]  = '{1,0,4'h0,4'b0000,3'd7,0,0,8'h00,0,0, 8'hA5,0};  // CLV
    vecs[3]  = '{1,0,4'h0,4'b0000,3'd5,0,0,8'h00,0,0, 8'hAD,0};  // SED
    vecs[4]  = '{1,0,4'h0,4'b0000,3'd4,0,0,8'h00,0,0, 8'hA9,0};  // CLI
    vecs[5]  = '{1,0,4'h0,4'b0000,3'd0,0,1,8'h00,0,1, 8'h30,0};  // PLP 0x00, brk shown
    vecs[6]  = '{1,0,4'h0,4'b0000,3'd0,1,0,8'hC0,0,0, 8'hE0,0};  // BIT loads N V
    vecs[7]  = '{0,0,4'h0,4'b0000,3'd1,0,0,8'h00,0,0, 8'hE0,0};  // SEC while stalled
    vecs[8]  = '{1,1,4'h1,4'b0000,3'd0,0,0,8'h00,0,0, 8'hE0,1};  // capture C
    vecs[9]  = '{0,0,4'h0,4'b0001,3'd0,0,0,8'h00,0,0, 8'hE0,1};  // stall holds pending
    vecs[10] = '{1,0,4'h0,4'b0001,3'd2,0,0,8'h00,0,0, 8'hE1,0};  // CLC loses to ALU
    vecs[11] = '{1,0,4'h0,4'b0000,3'd0,0,0,8'h00,1,1, 8'hF5,0};  // irq entry

    // Reset with RDY low.
    idle(); RDY = 1'b0; reset = 1'b1;
    tick_check("reset_rdy0", 8'h24, 1'b0);
    check("reset_flags", {2'b0, N, V, D, I, Z, C}, {2'b0, 1'b0, 1'b0, 1'b0, RESET_I, 1'b0, 1'b0});
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      drive(vecs[k]);
      tick_check($sformatf("vec%0d", k), vecs[k].exp_push, vecs[k].exp_pend);
    end

    // Stall: request, three RDY-low edges with changing ALU values, then apply at RDY rise.
    idle(); flag_req = 1'b1; flag_mask = 4'hF;
    tick_check("stall_cap", 8'hE5, 1'b1);
    idle(); RDY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      {alu_n, alu_v, alu_z, alu_co} = 4'(k + 8);
      tick_check($sformatf("stall%0d", k), 8'hE5, 1'b1);
    end
    RDY = 1'b1; {alu_n, alu_v, alu_z, alu_co} = 4'b0011;
    tick_check("stall_apply", 8'h27, 1'b0);

    // PLP beats a pending C update.
    idle(); flag_req = 1'b1; flag_mask = 4'h1;
    tick_check("plp_cap", 8'h27, 1'b1);
    idle(); plp_load = 1'b1; DI = 8'hFF;
    tick_check("plp_win", 8'hEF, 1'b0);

    // SEC loses to pending C apply, then SED drives BCD.
    idle(); flag_req = 1'b1; flag_mask = 4'h1;
    tick_check("sec_cap", 8'hEF, 1'b1);
    idle(); flag_op = 3'd1;
    tick_check("sec_alu", 8'hEE, 1'b0);
    idle(); flag_op = 3'd6;
    tick_check("cld", 8'hE6, 1'b0);
    idle(); flag_op = 3'd5;
    tick_check("sed", 8'hEE, 1'b0);
    check("bcd_out", {7'b0, D}, 8'h01);

    // Interrupt entry with D=1.
    idle(); irq_entry = 1'b1; brk = 1'b1;
`ifdef CMOS_FLAGS_EN
    tick_check("irq_d", 8'hF6, 1'b0);
`else
    tick_check("irq_d", 8'hFE, 1'b0);
`endif

    // Reset mid-pending discards the update.
    idle(); flag_req = 1'b1; flag_mask = 4'hF;
    @(posedge clk); #1;
    idle(); reset = 1'b1; {alu_n, alu_v, alu_z, alu_co} = 4'hF;
    tick_check("rst_mid", 8'h24, 1'b0);
    reset = 1'b0;
    tick_check("rst_after", 8'h24, 1'b0);

    // Randomized run against the reference model.
    idle(); reset = 1'b1;
    model_edge();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 600; k++) begin
      reset     = ($urandom_range(0, 59) == 0);
      RDY       = ($urandom_range(0, 4) != 0);
      flag_req  = 1'($urandom_range(0, 1));
      flag_mask = 4'($urandom);
      {alu_n, alu_v, alu_z, alu_co} = 4'($urandom);
      flag_op   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      bit_load  = ($urandom_range(0, 5) == 0);
      plp_load  = ($urandom_range(0, 7) == 0);
      irq_entry = ($urandom_range(0, 7) == 0);
      brk       = 1'($urandom_range(0, 1));
      DI        = 8'($urandom);
      model_edge();
      @(posedge clk); #1;
      check("rnd.push", P_push, {m_p[7:6], 1'b1, brk, m_p[3:0]});
      check("rnd.pend", {7'b0, pend}, {7'b0, m_pend});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_status_reg.md
Name: cpu_status_reg

Overview:
- Processor status (P) register stage directly downstream of the 8-bit ALU. It consumes the ALU's registered flag outputs (CO, V, Z, N) one cycle after an operation is issued, and merges them with flag set/clear instructions, BIT-operand loads, PLP/RTI bus loads and interrupt entry.
- Drives the carry and decimal bits back into the ALU's CI and BCD inputs.
- Produces the byte pushed to the stack.

Parameters:
- RESET_I, 1, value of the I flag after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RDY  in  1  global ready; when low all state is frozen.
- flag_req  in  1  the ALU op issued this cycle updates the flags selected by flag_mask.
- flag_mask  in  4  {N,V,Z,C} update-enable mask, captured with flag_req.
- alu_co  in  1  ALU carry out, valid the cycle after issue.
- alu_v  in  1  ALU overflow, valid the cycle after issue.
- alu_z  in  1  ALU zero, valid the cycle after issue.
- alu_n  in  1  ALU negative, valid the cycle after issue.
- flag_op  in  3  0 none, 1 SEC, 2 CLC, 3 SEI, 4 CLI, 5 SED, 6 CLD, 7 CLV.
- bit_load  in  1  BIT instruction: N<=DI[7], V<=DI[6].
- plp_load  in  1  load P from DI (PLP/RTI).
- DI  in  8  data input bus.
- irq_entry  in  1  interrupt/BRK vector entry; sets I.
- brk  in  1  B bit value presented in P_push.
- C, Z, I, D, V, N  out  1 each  current flags.
- P_push  out  8  {N,V,1,brk,D,I,Z,C}, combinational from current flags.
- pend  out  1  an ALU flag update is pending.

Behaviour:
- Reset (sync, high): C=Z=V=N=D=0, I=RESET_I, pend=0, pending mask=0. Reset overrides RDY.
- RDY=0: no state changes. The pending mask is held, and a pending update is applied on the next RDY=1 edge using the alu_* values present then. The ALU also holds its outputs while RDY is low.
- Pending pipeline:
  - Capture: on an edge with RDY=1 and flag_req=1, pend<=1 and pmask<=flag_mask.
  - Apply: on the next edge with RDY=1, each flag whose pmask bit is set takes its alu_* value; C takes alu_co.
  - Clear: pend<=0 at that edge unless a new flag_req is captured in the same cycle. Back-to-back requests are allowed, giving a throughput of one update per cycle.
  - Latency: flag_req at edge k means flags are visible after edge k+1.
- Single-cycle updates, effective at the next RDY edge:
  - flag_op: set or clear the named flag.
  - bit_load: N<=DI[7], V<=DI[6].
  - plp_load: {N,V,-,-,D,I,Z,C}<=DI; bits 5 and 4 are ignored.
  - irq_entry: I<=1.
- Per-flag priority within one edge (highest first): reset, plp_load, pending ALU apply, bit_load, flag_op, irq_entry.
  - A flag not selected by a higher source falls through to lower sources.
  - plp_load also cancels any pending update: pend<=0, unless flag_req is asserted in the same cycle, in which case the new request is captured.
- Simultaneous flag_op and pending apply on the same flag: the ALU value wins.
  - Example: ADC result pending, SEC issued → C = alu_co.
- P_push bit 5 is always 1; bit 4 = brk, purely combinational.
- C and D outputs connect directly to ALU CI and BCD. A pending C update is not forwarded: consumers issuing back-to-back carry-dependent ops wait one cycle (decoder responsibility).
- Reset asserted mid-pending discards the update.

Optional Feature:
- Macro CMOS_FLAGS_EN.
- Defined (65C02 behaviour): irq_entry also clears D, at the same priority level as its I update. bit_load with flag_mask[1] set (BIT immediate) suppresses the N/V load, so only Z is updated via the pipeline.
- Undefined (NMOS behaviour): irq_entry leaves D unchanged; bit_load always loads N/V.

Test Plan:
- Reset with RDY=0 → C=Z=V=N=D=0, I=1, pend=0, P_push=0x24 with brk=0.
- flag_req with mask 4'b1111, then alu_co=1, alu_v=1, alu_z=0, alu_n=1 next cycle → after second edge N=1, V=1, Z=0, C=1, pend=0; flags unchanged after first edge.
- flag_req issued, RDY low for 3 cycles, alu_* = {n0,v0,z1,c1} when RDY rises → Z=1, C=1 applied only at the first RDY=1 edge; pend held at 1 throughout the stall.
- plp_load DI=0xFF while a pending update with mask 4'b0001 and alu_co=0 is applied → P_push=0xEF with brk=0, so C=1 (PLP wins); pend=0.
- flag_op=SEC with pending mask C, alu_co=0 → C=0; next cycle flag_op=SED → D=1, ALU BCD high.
- D=1, irq_entry=1, brk=1 → I=1, P_push bit4=1; D=0 if CMOS_FLAGS_EN, else D=1.
